// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by the fetch path, the load/store path,
// the memory port arbiter and the unified memory macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BW = DATA_WIDTH / 8;

    logic                  i_if_req;
    logic [ADDR_WIDTH-1:0] i_if_addr;
    logic                  i_if_flush;
    logic                  o_if_gnt;
    logic                  o_if_rvalid;
    logic [DATA_WIDTH-1:0] o_if_rdata;

    logic                  i_ls_req;
    logic                  i_ls_we;
    logic [ADDR_WIDTH-1:0] i_ls_addr;
    logic [DATA_WIDTH-1:0] i_ls_wdata;
    logic [BW-1:0]         i_ls_be;
    logic                  o_ls_gnt;
    logic                  o_ls_rvalid;
    logic [DATA_WIDTH-1:0] o_ls_rdata;

    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [BW-1:0]         o_mem_be;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    logic                  o_busy;

    modport master (
        output i_if_req, i_if_addr, i_if_flush,
        output i_ls_req, i_ls_we, i_ls_addr,
        output i_ls_wdata, i_ls_be, i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr,
        input  o_mem_wdata, o_mem_be, o_busy
    );

    modport slave (
        input  i_if_req, i_if_addr, i_if_flush,
        input  i_ls_req, i_ls_we, i_ls_addr,
        input  i_ls_wdata, i_ls_be, i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_we, o_mem_addr,
        output o_mem_wdata, o_mem_be, o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch and load/store, one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input logic               i_clk,
    input logic               i_reset,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { OWN_IF, OWN_LS } owner_t;

    state_t        state;
    logic [CW-1:0] cnt;
    owner_t        owner;
    owner_t        last_grant;
    logic          flushed;
    logic          store_q;

    logic final_cyc;
    logic arb_en;
    logic gnt_if;
    logic gnt_ls;
    logic rsp;
    logic if_rv;
    logic ls_rv;

    assign final_cyc = (state == BUSY) && (cnt == LAT);
    assign arb_en    = !i_reset && (state == IDLE || final_cyc);

    // On a tie the requester that did not win last time goes first.
    assign gnt_ls = arb_en && bus.i_ls_req &&
                    (!bus.i_if_req || last_grant == OWN_IF);
    assign gnt_if = arb_en && bus.i_if_req && !gnt_ls;

    always_comb begin
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = {ADDR_WIDTH{1'b0}};
        bus.o_mem_wdata = {DATA_WIDTH{1'b0}};
        bus.o_mem_be    = {BW{1'b0}};
        unique case (1'b1)
            gnt_ls: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = bus.i_ls_we;
                bus.o_mem_addr  = bus.i_ls_addr;
                bus.o_mem_wdata = bus.i_ls_wdata;
                bus.o_mem_be    = bus.i_ls_be;
            end
            gnt_if: begin
                bus.o_mem_req  = 1'b1;
                bus.o_mem_addr = bus.i_if_addr;
                bus.o_mem_be   = {BW{1'b1}};
            end
            default: ;
        endcase
    end

    assign rsp   = final_cyc && !i_reset;
    assign if_rv = rsp && owner == OWN_IF && !flushed;
    assign ls_rv = rsp && owner == OWN_LS;

    assign bus.o_if_gnt    = gnt_if;
    assign bus.o_ls_gnt    = gnt_ls;
    assign bus.o_if_rvalid = if_rv;
    assign bus.o_ls_rvalid = ls_rv;
    assign bus.o_if_rdata  = if_rv ? bus.i_mem_rdata
                                   : {DATA_WIDTH{1'b0}};
    assign bus.o_ls_rdata  = (ls_rv && !store_q) ? bus.i_mem_rdata
                                                 : {DATA_WIDTH{1'b0}};
    assign bus.o_busy      = (state == BUSY) && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            flushed    <= 1'b0;
            store_q    <= 1'b0;
        end else if (gnt_if || gnt_ls) begin
            state      <= BUSY;
            cnt        <= CW'(1);
            owner      <= gnt_ls ? OWN_LS : OWN_IF;
            last_grant <= gnt_ls ? OWN_LS : OWN_IF;
            flushed    <= gnt_if && bus.i_if_flush;
            store_q    <= gnt_ls && bus.i_ls_we;
        end else if (state == BUSY) begin
            if (final_cyc) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (owner == OWN_IF && bus.i_if_flush)
                flushed <= 1'b1;
        end
    end
endmodule
